// File: rtl/wb_stage.sv
// Writeback stage: retires one instruction per cycle to the register bank write port; loads wait for memory data.
// Latency: non-load writes 1 cycle after acceptance; load writes 1 cycle after the mem_rvalid cycle.
// Backpressure: in_ready drops for the whole time a load waits for memory; upstream must hold its instruction.
module wb_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_rd,
   input  logic        in_is_load,
   input  logic [2:0]  in_funct3,
   input  logic [1:0]  in_addr_lo,
   input  logic [31:0] in_alu_result,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        reg_we,
   output logic [4:0]  rd,
   output logic [31:0] rd_val,
   output logic        pend_valid,
   output logic [4:0]  pend_rd,
   output logic        err
);

   typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [4:0]  ld_rd_q;
   logic [2:0]  ld_funct3_q;
   logic [1:0]  ld_addr_q;
   logic        accept;
   logic        reg_we_d;
   logic [4:0]  rd_d;
   logic [31:0] rd_val_d;

   // Select the addressed byte/halfword/word and extend it; unused funct3 codes fall back to a full word.
   function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                input logic [1:0]  alo,
                                                input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      case (alo)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = alo[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  res = {{24{b[7]}}, b};
         3'b001:  res = {{16{h[15]}}, h};
         3'b100:  res = {24'd0, b};
         3'b101:  res = {16'd0, h};
         default: res = w;
      endcase
      return res;
   endfunction

   assign in_ready = (state_q == IDLE);
   assign accept   = in_valid && in_ready;
   assign pend_rd  = ld_rd_q;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state: a load parks us in WAIT_MEM until its data returns.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (accept && in_is_load) state_d = WAIT_MEM;
         WAIT_MEM: if (mem_rvalid)           state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Next writeback values; rd/rd_val hold unless a write (possibly to x0) is retiring.
   always_comb begin
      reg_we_d = 1'b0;
      rd_d     = rd;
      rd_val_d = rd_val;
      case (state_q)
         IDLE: begin
            if (accept && !in_is_load) begin
               reg_we_d = (in_rd != 5'd0);
               rd_d     = in_rd;
               rd_val_d = in_alu_result;
            end
         end
         WAIT_MEM: begin
            if (mem_rvalid) begin
               reg_we_d = (ld_rd_q != 5'd0);
               rd_d     = ld_rd_q;
               rd_val_d = load_extract(ld_funct3_q, ld_addr_q, mem_rdata);
            end
         end
         default: ;
      endcase
   end

   // Registered outputs, pending-load bookkeeping and the sticky stray-response flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_we      <= 1'b0;
         rd          <= 5'd0;
         rd_val      <= 32'd0;
         pend_valid  <= 1'b0;
         ld_rd_q     <= 5'd0;
         ld_funct3_q <= 3'd0;
         ld_addr_q   <= 2'd0;
         err         <= 1'b0;
      end else begin
         reg_we     <= reg_we_d;
         rd         <= rd_d;
         rd_val     <= rd_val_d;
         pend_valid <= (state_d == WAIT_MEM);
         if (accept && in_is_load) begin
            ld_rd_q     <= in_rd;
            ld_funct3_q <= in_funct3;
            ld_addr_q   <= in_addr_lo;
         end
         if (state_q == IDLE && mem_rvalid) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  in_rd = '0;
   logic        in_is_load = 1'b0;
   logic [2:0]  in_funct3 = '0;
   logic [1:0]  in_addr_lo = '0;
   logic [31:0] in_alu_result = '0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        reg_we;
   logic [4:0]  rd;
   logic [31:0] rd_val;
   logic        pend_valid;
   logic [4:0]  pend_rd;
   logic        err;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] val;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   wb_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_rd(in_rd), .in_is_load(in_is_load), .in_funct3(in_funct3),
      .in_addr_lo(in_addr_lo), .in_alu_result(in_alu_result),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .reg_we(reg_we),
      .rd(rd), .rd_val(rd_val), .pend_valid(pend_valid), .pend_rd(pend_rd),
      .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every write pulse must match the oldest expectation, including its cycle.
   always @(negedge clk) begin
      if (rst_n && reg_we) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_reg_we", {27'd0, rd}, 32'h0000_0fff);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("wb_rd", {27'd0, rd}, {27'd0, e.rd});
            chk("wb_val", rd_val, e.val);
            chk("wb_cycle", cyc, e.cyc);
         end
      end
   end

   // Present one instruction and hold it until accepted (bounded wait).
   task automatic send(input logic [4:0] r, input logic ld, input logic [2:0] f3,
                       input logic [1:0] alo, input logic [31:0] alu);
      int n;
      in_valid = 1'b1; in_rd = r; in_is_load = ld; in_funct3 = f3;
      in_addr_lo = alo; in_alu_result = alu;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
      if (!ld && r != 5'd0) exp_q.push_back('{r, alu, cyc + 1});
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Return load data for the outstanding load, expecting a writeback of v to r.
   task automatic mem_resp(input logic [31:0] d, input logic [4:0] r, input logic [31:0] v);
      mem_rvalid = 1'b1; mem_rdata = d;
      if (r != 5'd0) exp_q.push_back('{r, v, cyc + 1});
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
   endtask

   task automatic load(input logic [4:0] r, input logic [2:0] f3, input logic [1:0] alo,
                       input logic [31:0] d, input logic [31:0] v);
      send(r, 1'b1, f3, alo, 32'h0);
      mem_resp(d, r, v);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_reg_we", {31'd0, reg_we}, 32'd0);
      chk("rst_rd", {27'd0, rd}, 32'd0);
      chk("rst_rd_val", rd_val, 32'd0);
      chk("rst_pend_valid", {31'd0, pend_valid}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Back-to-back non-loads.
      send(5'd5, 1'b0, 3'd0, 2'd0, 32'h11);
      send(5'd6, 1'b0, 3'd0, 2'd0, 32'h22);
      send(5'd7, 1'b0, 3'd0, 2'd0, 32'h33);
      @(posedge clk); #1;

      // Write to x0 is suppressed but data still lands on the port.
      send(5'd0, 1'b0, 3'd0, 2'd0, 32'hDEADBEEF);
      chk("x0_reg_we", {31'd0, reg_we}, 32'd0);
      chk("x0_rd_val", rd_val, 32'hDEADBEEF);
      chk("x0_rd", {27'd0, rd}, 32'd0);

      // LB with data returning three cycles after acceptance.
      send(5'd9, 1'b1, 3'b000, 2'd2, 32'h0);
      chk("lb_in_ready", {31'd0, in_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         chk("lb_pend_valid", {31'd0, pend_valid}, 32'd1);
         chk("lb_pend_rd", {27'd0, pend_rd}, 32'd9);
         if (i < 2) begin
            @(posedge clk); #1;
         end
      end
      mem_resp(32'h1280_3456, 5'd9, 32'hFFFF_FF80);
      chk("lb_pend_cleared", {31'd0, pend_valid}, 32'd0);
      chk("lb_in_ready_back", {31'd0, in_ready}, 32'd1);

      // Halfword/byte/word extraction variants.
      load(5'd10, 3'b101, 2'd2, 32'h8001_7FFF, 32'h0000_8001);
      load(5'd11, 3'b001, 2'd2, 32'h8001_7FFF, 32'hFFFF_8001);
      load(5'd12, 3'b001, 2'd1, 32'h8001_7FFF, 32'h0000_7FFF);
      load(5'd13, 3'b010, 2'd3, 32'h8001_7FFF, 32'h8001_7FFF);
      load(5'd14, 3'b100, 2'd3, 32'h8001_7FFF, 32'h0000_0080);
      load(5'd17, 3'b111, 2'd1, 32'hCAFE_F00D, 32'hCAFE_F00D);
      load(5'd18, 3'b000, 2'd0, 32'h1234_567F, 32'h0000_007F);

      // Held instruction during WAIT_MEM is accepted only after returning to IDLE.
      send(5'd15, 1'b1, 3'b010, 2'd0, 32'h0);
      fork
         send(5'd16, 1'b0, 3'd0, 2'd0, 32'h55);
         begin
            @(posedge clk); #1;
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            mem_resp(32'hA5A5_0001, 5'd15, 32'hA5A5_0001);
         end
      join
      @(posedge clk); #1;

      // Stray response in IDLE sets sticky err with no writeback.
      chk("err_before", {31'd0, err}, 32'd0);
      mem_resp(32'h1111_2222, 5'd0, 32'h0);
      chk("err_set", {31'd0, err}, 32'd1);
      repeat (3) @(posedge clk);
      #1 chk("err_sticky", {31'd0, err}, 32'd1);

      // Reset mid-WAIT_MEM clears everything asynchronously.
      send(5'd20, 1'b1, 3'b010, 2'd0, 32'h0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_pend_valid", {31'd0, pend_valid}, 32'd0);
      chk("arst_pend_rd", {27'd0, pend_rd}, 32'd0);
      chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("arst_rd_val", rd_val, 32'd0);
      chk("arst_rd", {27'd0, rd}, 32'd0);
      chk("arst_err", {31'd0, err}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      mem_resp(32'h3333_4444, 5'd0, 32'h0);
      chk("late_rvalid_err", {31'd0, err}, 32'd1);

      repeat (3) @(posedge clk);
      #1 chk("queue_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the RISC-V core. It accepts one retiring instruction per cycle from the execute/memory stage and drives the register bank write port (reg_we, rd, rd_val). For loads it waits for the data-memory response, then extracts and sign- or zero-extends the addressed byte, halfword or word. It also reports the destination of an outstanding load so decode can stall on load-use hazards.

## Interface
Parameters: none. Data width is fixed at 32 bits and register addresses at 5 bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  retiring instruction present
- in_ready  out  1  stage can accept an instruction this cycle
- in_rd  in  5  destination register
- in_is_load  in  1  instruction is a load
- in_funct3  in  3  load width and sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- in_addr_lo  in  2  low two bits of the load byte address
- in_alu_result  in  32  result of a non-load instruction
- mem_rvalid  in  1  load data valid this cycle
- mem_rdata  in  32  aligned 32-bit memory word
- reg_we  out  1  register bank write enable
- rd  out  5  register bank write address
- rd_val  out  32  register bank write data
- pend_valid  out  1  a load is outstanding
- pend_rd  out  5  destination of the outstanding load
- err  out  1  sticky: mem_rvalid arrived in IDLE

## Operation
- Two states: IDLE and WAIT_MEM.
- in_ready = (state == IDLE).
- An instruction is accepted when in_valid && in_ready.
- Non-load accepted in IDLE:
  - Next cycle: reg_we = (in_rd != 0), rd = in_rd, rd_val = in_alu_result.
  - State stays IDLE, so back-to-back non-loads run at one per cycle.
- Load accepted in IDLE:
  - Latch rd, funct3 and addr_lo; go to WAIT_MEM.
  - reg_we = 0 in the next cycle.
  - pend_valid = 1 and pend_rd = latched rd for the whole time the state is WAIT_MEM.
- WAIT_MEM with mem_rvalid = 1:
  - Next cycle: reg_we = (rd != 0) and rd_val = extracted value; return to IDLE.
  - A new instruction can be accepted in the cycle after the return to IDLE, not in the same cycle as mem_rvalid.
- WAIT_MEM with mem_rvalid = 0: hold state; reg_we = 0.
- Extraction from mem_rdata:
  - Byte: mem_rdata[8*addr_lo +: 8].
  - Halfword: mem_rdata[16*addr_lo[1] +: 16]; addr_lo[0] is ignored.
  - Word: mem_rdata unchanged; addr_lo is ignored.
  - LB and LH sign-extend from bit 7 / bit 15. LBU and LHU zero-extend.
  - funct3 values 011, 110 and 111 are treated as LW.
- Writes to x0 are suppressed: reg_we stays 0, but rd and rd_val still update.
- mem_rvalid in IDLE is ignored for writeback and sets err. err is cleared only by reset.
- in_valid while in WAIT_MEM: the instruction is not accepted and upstream must hold it. The stage keeps no input state for it.

## Timing
- All outputs except in_ready are registered.
- in_ready is decoded combinationally from the state register.
- Latency from acceptance to reg_we:
  - non-load: 1 cycle
  - load: 1 cycle after the mem_rvalid cycle
- reg_we is a single-cycle pulse per instruction.
- Reset values, applied asynchronously on rst_n low:
  - state = IDLE
  - reg_we = 0, rd = 0, rd_val = 0
  - pend_valid = 0, pend_rd = 0
  - err = 0
  - in_ready = 1
- Reset during WAIT_MEM drops the outstanding load. A mem_rvalid arriving after reset release sets err.
- Reset release is synchronised externally. The block only requires that rst_n deassertion meets recovery timing to clk.

## Test plan
- Reset: assert rst_n = 0 mid-WAIT_MEM -> all outputs zero immediately, in_ready = 1, pend_valid = 0.
- Back-to-back non-loads: in_rd = 5, 6, 7 with results 0x11, 0x22, 0x33 on consecutive cycles -> reg_we high for 3 consecutive cycles, each starting one cycle after its input, with matching rd/rd_val.
- LB sign extension: addr_lo = 2, mem_rdata = 0x12_80_34_56, rd = 9, rvalid 3 cycles after accept -> pend_valid high for 3 cycles with pend_rd = 9, then rd_val = 0xFFFFFF80, reg_we = 1.
- LHU and LH: mem_rdata = 0x8001_7FFF, addr_lo = 2 -> LHU gives 0x00008001 and LH gives 0xFFFF8001. With addr_lo = 1, LH gives 0x00007FFF.
- x0 write: non-load with in_rd = 0 and result 0xDEADBEEF -> reg_we = 0, rd_val = 0xDEADBEEF.
- Stall and error: in_valid held high during WAIT_MEM -> in_ready = 0 and the held instruction is accepted only after the return to IDLE. A stray mem_rvalid in IDLE -> err = 1 and remains set until reset.
